// File: rtl/conv_pkg.sv
// Shared definitions for the convolution slice column: the sequencer state
// encoding, the MAC pipeline depth and the drain-length helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Register stages per MAC; the slice datapath uses the same value.
    localparam int PIPELINE = 6;

    // Cycles to wait after the last image beat before products have left
    // every MAC of a slice, plus the output adder and result register.
    function automatic int drain_cycles(input int mac_nb);
        return PIPELINE * mac_nb + 2;
    endfunction

endpackage

// File: rtl/slice_sequencer_if.sv
// Handshake bundle between the config/DMA front end, the sequencer and the
// slice column. The front end is the master; the sequencer is the slave.
interface slice_sequencer_if #(
    parameter int MAC_NB       = 3,
    parameter int SLICE_NB     = 3,
    parameter int WEIGHT_WIDTH = 16,
    parameter int IMAGE_WIDTH  = 16
);
    logic [WEIGHT_WIDTH-1:0]         cfg_weight;
    logic                            cfg_valid;
    logic                            cfg_ready;
    logic                            keep_weights;
    logic [IMAGE_WIDTH*MAC_NB-1:0]   img_data;
    logic                            img_valid;
    logic                            img_last;
    logic                            img_ready;
    logic [WEIGHT_WIDTH-1:0]         weight;
    logic [SLICE_NB*MAC_NB-1:0]      weight_valid;
    logic [IMAGE_WIDTH*MAC_NB-1:0]   image;
    logic                            image_valid;
    logic                            loaded;
    logic                            done;

    modport master (
        output cfg_weight, cfg_valid, keep_weights, img_data, img_valid, img_last,
        input  cfg_ready, img_ready, weight, weight_valid, image, image_valid,
               loaded, done
    );

    modport slave (
        input  cfg_weight, cfg_valid, keep_weights, img_data, img_valid, img_last,
        output cfg_ready, img_ready, weight, weight_valid, image, image_valid,
               loaded, done
    );
endinterface

// File: rtl/slice_sequencer.sv
// Kernel loader and image gate for a column of slice datapaths: steers the
// serial weight stream to one MAC at a time, opens the image path once the
// full kernel is resident, then drains the MAC pipeline after each frame.
module slice_sequencer
    import conv_pkg::*;
#(
    parameter int MAC_NB       = 3,
    parameter int SLICE_NB     = 3,
    parameter int WEIGHT_WIDTH = 16,
    parameter int IMAGE_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    slice_sequencer_if.slave  bus
);

    localparam int TOTAL   = SLICE_NB * MAC_NB;
    localparam int WCNT_W  = $clog2(TOTAL + 1);
    localparam int DRAIN_N = drain_cycles(MAC_NB);
    localparam int DCNT_W  = $clog2(DRAIN_N + 1);

    seq_state_t                    state;
    logic [WCNT_W-1:0]             wcnt;
    logic [DCNT_W-1:0]             dcnt;
    logic [WEIGHT_WIDTH-1:0]       weight_p1;
    logic [TOTAL-1:0]              wvld_p1;
    logic [IMAGE_WIDTH*MAC_NB-1:0] image_p1;
    logic                          vld_p1;
    logic                          loaded_q;
    logic                          done_p1;
    logic                          cfg_fire;
    logic                          img_fire;

    // Ready depends on state only, so it is valid straight out of reset.
    assign bus.cfg_ready = (state == IDLE) || (state == LOAD);
    assign bus.img_ready = (state == RUN);
    assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;
    assign img_fire      = bus.img_valid & bus.img_ready;

    // ---- stage p1: registered outputs toward the slices ----
    assign bus.weight       = weight_p1;
    assign bus.weight_valid = wvld_p1;
    assign bus.image        = image_p1;
    assign bus.image_valid  = vld_p1;
    assign bus.loaded       = loaded_q;
    assign bus.done         = done_p1;

    // Sequencer FSM with counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wcnt      <= '0;
            dcnt      <= '0;
            weight_p1 <= '0;
            wvld_p1   <= '0;
            image_p1  <= '0;
            vld_p1    <= 1'b0;
            loaded_q  <= 1'b0;
            done_p1   <= 1'b0;
        end else begin
            wvld_p1 <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (cfg_fire) begin
                weight_p1 <= bus.cfg_weight;
            end
            case (state)
                IDLE: begin
                    wcnt     <= '0;
                    loaded_q <= 1'b0;
                    if (cfg_fire) begin
                        wvld_p1 <= TOTAL'(1);
                        if (TOTAL == 1) begin
                            state    <= RUN;
                            loaded_q <= 1'b1;
                        end else begin
                            state <= LOAD;
                            wcnt  <= WCNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (cfg_fire) begin
                        wvld_p1 <= TOTAL'(1) << wcnt;
                        wcnt    <= wcnt + WCNT_W'(1);
                        if (wcnt == WCNT_W'(TOTAL - 1)) begin
                            state    <= RUN;
                            loaded_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (img_fire) begin
                        image_p1 <= bus.img_data;
                        vld_p1   <= 1'b1;
                        if (bus.img_last) begin
                            state <= DRAIN;
                            dcnt  <= DCNT_W'(DRAIN_N - 1);
                        end
                    end
                end
                DRAIN: begin
                    if (dcnt == '0) begin
                        done_p1 <= 1'b1;
                        if (bus.keep_weights) begin
                            state <= RUN;
                        end else begin
                            state    <= IDLE;
                            loaded_q <= 1'b0;
                            wcnt     <= '0;
                        end
                    end else begin
                        dcnt <= dcnt - DCNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Controller that loads a convolution kernel into a column of `slice` datapaths and then gates the image stream into them. It accepts a serial weight stream and steers each word to exactly one MAC through one-hot `weight_valid` strobes. It opens the image path only once the full kernel is resident, and drains the MAC pipeline after the last image beat so weights are never changed while products are in flight. It sits between the configuration/DMA front end and the array of `slice` instances.

## Interface
- `MAC_NB`, 3, MACs per slice (kernel width)
- `SLICE_NB`, 3, slices driven (kernel height)
- `WEIGHT_WIDTH`, 16, weight word width
- `IMAGE_WIDTH`, 16, image word width per MAC lane
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `cfg_weight`  in  WEIGHT_WIDTH  kernel word
- `cfg_valid`  in  1  kernel word valid
- `cfg_ready`  out  1  kernel word accepted when `cfg_valid & cfg_ready`
- `keep_weights`  in  1  sampled at DRAIN exit: 1 = reuse the kernel for the next frame
- `img_data`  in  IMAGE_WIDTH*MAC_NB  image beat from upstream
- `img_valid`  in  1  upstream beat valid
- `img_last`  in  1  last beat of frame, qualified by the accepted beat
- `img_ready`  out  1  upstream beat accepted when `img_valid & img_ready`
- `weight`  out  WEIGHT_WIDTH  broadcast weight to all slices
- `weight_valid`  out  SLICE_NB*MAC_NB  one-hot load strobe; slice s uses bits `[s*MAC_NB +: MAC_NB]`
- `image`  out  IMAGE_WIDTH*MAC_NB  image to slices
- `image_valid`  out  1  image valid to slices
- `loaded`  out  1  full kernel resident
- `done`  out  1  one-cycle pulse at end of frame drain

## Operation
- States: IDLE, LOAD, RUN, DRAIN. State resets to IDLE.
- Word counter `wcnt` has width `$clog2(SLICE_NB*MAC_NB+1)`. TOTAL = SLICE_NB*MAC_NB.
- `cfg_ready` = (state is IDLE or LOAD). It is combinational, so it reads 1 during and after reset.
- `img_ready` = (state is RUN). It is combinational.
- IDLE:
  - `wcnt` = 0 and `loaded` = 0.
  - An accepted word goes to index 0.
  - Next state is RUN if TOTAL = 1, else LOAD.
- LOAD:
  - Each accepted word goes to index `wcnt`, then `wcnt` increments.
  - Accepting index TOTAL-1 moves to RUN and sets `loaded` = 1.
  - Words are ordered slice-major: index i maps to slice i/MAC_NB, MAC i%MAC_NB.
- Weight write, for each accepted word at index i:
  - `weight` is registered from `cfg_weight`.
  - `weight_valid` is registered as `1 << i`.
  - Otherwise `weight_valid` = 0, and `weight` holds its last value.
- RUN:
  - For each accepted beat, `image` is registered from `img_data` and `image_valid` = 1; otherwise `image_valid` = 0.
  - A beat accepted with `img_last` = 1 moves to DRAIN and loads the drain counter with DRAIN_CYCLES - 1.
- DRAIN:
  - DRAIN_CYCLES = PIPELINE*MAC_NB + 2, where PIPELINE = 6; this is 20 for MAC_NB = 3.
  - No weight or image traffic is accepted.
  - The counter decrements each cycle. On the cycle it reads 0, `done` is registered high for one cycle.
  - If `keep_weights` = 1, the next state is RUN and `loaded` stays 1.
  - If `keep_weights` = 0, the next state is IDLE, `loaded` is cleared and `wcnt` is cleared.
- `cfg_valid` in RUN or DRAIN is ignored; the word is held upstream by `cfg_ready` = 0.
- `img_valid` outside RUN is ignored and the beat is held upstream.

## Timing
- Reset values:
  - `weight_valid` = 0, `weight` = 0, `image` = 0, `image_valid` = 0, `loaded` = 0, `done` = 0.
  - Counters are 0.
  - `cfg_ready` = 1 and `img_ready` = 0.
- Latency:
  - `cfg` handshake to `weight_valid`: 1 cycle.
  - `img` handshake to `image_valid`: 1 cycle.
  - Last `cfg` handshake to `img_ready` = 1: next cycle.
  - Last image beat to `done`: DRAIN_CYCLES + 1 cycles. The beat is accepted at cycle 0, DRAIN occupies cycles 1..DRAIN_CYCLES, and `done` is high at cycle DRAIN_CYCLES + 1.
- `img_ready` falls in the cycle after the `img_last` handshake. No beat is accepted in DRAIN.
- `cfg` is back-pressure safe: gaps in `cfg_valid` stall `wcnt` with no strobe issued.
- Reset asserted mid-LOAD or mid-RUN:
  - All outputs clear asynchronously and the partial kernel is discarded.
  - After reset the full TOTAL words must be reloaded.

## Structure
- Shared package `conv_pkg` holds:
  - the state enum `seq_state_t`
  - `localparam PIPELINE = 6`
  - function `drain_cycles(mac_nb)`
- `slice` uses the same PIPELINE constant from `conv_pkg`.
- Single module, no sub-module.

## Test plan
- **Kernel load:** with defaults, send words 1..9 back-to-back.
  - `weight_valid` steps through 0x001, 0x002, …, 0x100 with `weight` = 1..9.
  - `loaded` = 1 and `img_ready` = 1 in the cycle after word 9.
- **Load back-pressure:** drop `cfg_valid` for 3 cycles after word 4.
  - No strobe is issued during the gap; word 5 strobes 0x010.
  - `img_ready` stays 0 until word 9 is accepted.
- **Frame and drain:** after load, send 4 image beats with `img_last` on beat 4.
  - `image_valid` is high for 4 cycles, each 1 cycle late.
  - `img_ready` falls after beat 4; `done` pulses exactly 21 cycles after beat 4.
  - With `keep_weights` = 0: `loaded` = 0 and `cfg_ready` = 1.
- **Kernel reuse:** as the frame test with `keep_weights` = 1.
  - The state returns to RUN and `img_ready` = 1 right after `done`.
  - A second frame is accepted with no cfg traffic.
- **Reset mid-load:** drive `rst` = 0 after 4 words.
  - `weight_valid` = 0 and `loaded` = 0.
  - After release, the next word strobes 0x001.
- **Stray traffic:** hold `img_valid` = 1 during LOAD and `cfg_valid` = 1 during RUN.
  - Neither handshake completes until its own phase.
